// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states and a
// width-generic two's-complement helper used by the CPU control path too.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

  // Widest value ever negated; callers zero-extend and keep the low bits.
  localparam int MDU_MAX_W = 128;

  function automatic logic [MDU_MAX_W-1:0] mdu_neg(input logic [MDU_MAX_W-1:0] x);
    return ~x + MDU_MAX_W'(1);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restore-subtract for divide.
module mdu_step #(
  parameter int DATA_W = 32
) (
  input  logic              i_is_div,
  input  logic [DATA_W:0]   i_hi,
  input  logic [DATA_W-1:0] i_lo,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W:0]   o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W+1:0] w_diff;
  logic              w_borrow;
  logic              w_unused;

  // Multiply keeps the carry of the partial sum; divide needs the borrow.
  assign w_sum    = {1'b0, i_hi[DATA_W-1:0]} + (i_lo[0] ? {1'b0, i_b} : '0);
  assign w_shift  = {i_hi[DATA_W-1:0], i_lo[DATA_W-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, i_b};
  assign w_borrow = w_diff[DATA_W+1];
  assign w_unused = i_hi[DATA_W];

  always_comb begin
    if (i_is_div) begin
      o_hi = w_borrow ? w_shift : w_diff[DATA_W:0];
      o_lo = {i_lo[DATA_W-2:0], ~w_borrow};
    end else begin
      o_hi = {1'b0, w_sum[DATA_W:1]};
      o_lo = {w_sum[0], i_lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/iter_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one radix-2 step per cycle, sign fix-up
// in a final cycle, result held in HI/LO until the next completion.
module iter_mdu
  import mdu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);

  mdu_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W:0]   r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_b;
  logic              r_is_div;
  logic              r_dz;
  logic              r_neg_hi;
  logic              r_neg_lo;
  logic              r_done;
  logic [DATA_W-1:0] r_hi_out;
  logic [DATA_W-1:0] r_lo_out;
  logic              r_div_by_zero;

  logic                    w_is_div;
  logic                    w_signed;
  logic                    w_sign_a;
  logic                    w_sign_b;
  logic                    w_b_zero;
  logic [MDU_MAX_W-1:0]    w_neg_a_x;
  logic [MDU_MAX_W-1:0]    w_neg_b_x;
  logic [DATA_W-1:0]       w_mag_a;
  logic [DATA_W-1:0]       w_mag_b;
  logic [2*DATA_W-1:0]     w_prod;
  logic [MDU_MAX_W-1:0]    w_neg_prod_x;
  logic [MDU_MAX_W-1:0]    w_neg_q_x;
  logic [MDU_MAX_W-1:0]    w_neg_r_x;
  logic [DATA_W-1:0]       w_fix_hi;
  logic [DATA_W-1:0]       w_fix_lo;
  logic [DATA_W:0]         w_step_hi;
  logic [DATA_W-1:0]       w_step_lo;
  logic                    w_unused;

  assign w_is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
  assign w_signed  = (op == MDU_MULT) || (op == MDU_DIV);
  assign w_sign_a  = w_signed & operand_a[DATA_W-1];
  assign w_sign_b  = w_signed & operand_b[DATA_W-1];
  assign w_b_zero  = (operand_b == '0);
  assign w_neg_a_x = mdu_neg(MDU_MAX_W'(operand_a));
  assign w_neg_b_x = mdu_neg(MDU_MAX_W'(operand_b));
  assign w_mag_a   = w_sign_a ? w_neg_a_x[DATA_W-1:0] : operand_a;
  assign w_mag_b   = w_sign_b ? w_neg_b_x[DATA_W-1:0] : operand_b;

  // Fix-up: multiply negates the whole product, divide fixes q and r apart.
  assign w_prod       = {r_hi[DATA_W-1:0], r_lo};
  assign w_neg_prod_x = mdu_neg(MDU_MAX_W'(w_prod));
  assign w_neg_q_x    = mdu_neg(MDU_MAX_W'(r_lo));
  assign w_neg_r_x    = mdu_neg(MDU_MAX_W'(r_hi[DATA_W-1:0]));

  always_comb begin
    w_fix_hi = r_hi[DATA_W-1:0];
    w_fix_lo = r_lo;
    if (r_dz) begin
      w_fix_hi = r_hi[DATA_W-1:0];
      w_fix_lo = r_lo;
    end else if (r_is_div) begin
      w_fix_lo = r_neg_lo ? w_neg_q_x[DATA_W-1:0] : r_lo;
      w_fix_hi = r_neg_hi ? w_neg_r_x[DATA_W-1:0] : r_hi[DATA_W-1:0];
    end else if (r_neg_lo) begin
      {w_fix_hi, w_fix_lo} = w_neg_prod_x[2*DATA_W-1:0];
    end
  end

  assign w_unused = ^{w_neg_a_x[MDU_MAX_W-1:DATA_W], w_neg_b_x[MDU_MAX_W-1:DATA_W],
                      w_neg_prod_x[MDU_MAX_W-1:2*DATA_W], w_neg_q_x[MDU_MAX_W-1:DATA_W],
                      w_neg_r_x[MDU_MAX_W-1:DATA_W]};

  mdu_step #(.DATA_W(DATA_W)) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_b      (r_b),
    .o_hi     (w_step_hi),
    .o_lo     (w_step_lo)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_b           <= '0;
      r_is_div      <= 1'b0;
      r_dz          <= 1'b0;
      r_neg_hi      <= 1'b0;
      r_neg_lo      <= 1'b0;
      r_done        <= 1'b0;
      r_hi_out      <= '0;
      r_lo_out      <= '0;
      r_div_by_zero <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div      <= w_is_div;
            r_dz          <= w_is_div & w_b_zero;
            r_neg_lo      <= w_sign_a ^ w_sign_b;
            r_neg_hi      <= w_sign_a;
            r_div_by_zero <= 1'b0;
            r_cnt         <= CNT_W'(DATA_W);
            if (w_is_div && w_b_zero) begin
              r_hi    <= {1'b0, operand_a};
              r_lo    <= '1;
              r_b     <= '0;
              r_state <= FIX;
            end else begin
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_mag_a : w_mag_b;
              r_b     <= w_is_div ? w_mag_b : w_mag_a;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= FIX;
        end
        FIX: begin
          r_hi_out <= w_fix_hi;
          r_lo_out <= w_fix_lo;
          r_done   <= 1'b1;
          if (r_dz) r_div_by_zero <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign hi          = r_hi_out;
  assign lo          = r_lo_out;
  assign div_by_zero = r_div_by_zero;

endmodule
